// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared types and constants for the data-memory arbiter and memoria_de_dados.
// MEM_SIZE_PADRAO is the single source of the memory depth for both blocks.
package pkg_memoria;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ACESSO   = 2'd1,
      RESPOSTA = 2'd2
   } estado_t;

   typedef logic id_t;

   localparam id_t CPU = 1'b0;
   localparam id_t DMA = 1'b1;

   localparam int unsigned MEM_SIZE_PADRAO = 150;

   function automatic logic endereco_valido(input logic [31:0] endereco,
                                            input int unsigned  tamanho);
      return endereco < tamanho;
   endfunction

endpackage

// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and memoria_de_dados.
// slave is the arbiter's view; master is the requester/memory side.
interface arbitro_memoria_dados_if;

   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_endereco;
   logic [31:0] cpu_dado_escrito;
   logic        cpu_ack;
   logic [31:0] cpu_dado_lido;
   logic        cpu_erro;

   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_endereco;
   logic [31:0] dma_dado_escrito;
   logic        dma_ack;
   logic [31:0] dma_dado_lido;
   logic        dma_erro;

   logic [31:0] mem_endereco;
   logic        mem_memWrite;
   logic [31:0] mem_dado_escrito;
   logic [31:0] mem_dado_lido;

   modport slave (
      input  cpu_req, cpu_we, cpu_endereco, cpu_dado_escrito,
      output cpu_ack, cpu_dado_lido, cpu_erro,
      input  dma_req, dma_we, dma_endereco, dma_dado_escrito,
      output dma_ack, dma_dado_lido, dma_erro,
      output mem_endereco, mem_memWrite, mem_dado_escrito,
      input  mem_dado_lido
   );

   modport master (
      output cpu_req, cpu_we, cpu_endereco, cpu_dado_escrito,
      input  cpu_ack, cpu_dado_lido, cpu_erro,
      output dma_req, dma_we, dma_endereco, dma_dado_escrito,
      input  dma_ack, dma_dado_lido, dma_erro,
      input  mem_endereco, mem_memWrite, mem_dado_escrito,
      output mem_dado_lido
   );

endinterface

// File: rtl/arbitro_memoria_dados_seletor.sv
// Combinational winner selection: fixed CPU priority, DMA wins a contest
// once the starvation limit has been reached.
module seletor_prioridade
   import pkg_memoria::*;
(
   input  logic cpu_req,
   input  logic dma_req,
   input  logic limite_atingido,
   output logic concede,
   output id_t  vencedor
);

   always_comb begin
      concede  = cpu_req | dma_req;
      vencedor = CPU;
      if (cpu_req && dma_req) begin
         vencedor = limite_atingido ? DMA : CPU;
      end else if (dma_req) begin
         vencedor = DMA;
      end
   end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter/sequencer in front of memoria_de_dados: grant, one access
// cycle and one response cycle per transaction.
module arbitro_memoria_dados
   import pkg_memoria::*;
#(
   parameter int unsigned MEM_SIZE     = MEM_SIZE_PADRAO,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                     clock,
   input logic                     reset,
   arbitro_memoria_dados_if.slave  bus
);

   localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMITE = CW'(STARVE_LIMIT);

   estado_t       estado_q, estado_d;
   id_t           vencedor_q, vencedor_d;
   logic          we_q, we_d;
   logic          in_range_q, in_range_d;
   logic [31:0]   endereco_q, endereco_d;
   logic [31:0]   dado_q, dado_d;
   logic [CW-1:0] contador_q, contador_d;
   logic [31:0]   cpu_dado_lido_q, cpu_dado_lido_d;
   logic          cpu_erro_q, cpu_erro_d;
   logic [31:0]   dma_dado_lido_q, dma_dado_lido_d;
   logic          dma_erro_q, dma_erro_d;

   logic          concede;
   id_t           vencedor;
   logic [31:0]   leitura;

   seletor_prioridade u_seletor (
      .cpu_req         (bus.cpu_req),
      .dma_req         (bus.dma_req),
      .limite_atingido (contador_q == LIMITE),
      .concede         (concede),
      .vencedor        (vencedor)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q        <= OCIOSO;
         vencedor_q      <= CPU;
         we_q            <= 1'b0;
         in_range_q      <= 1'b0;
         endereco_q      <= '0;
         dado_q          <= '0;
         contador_q      <= '0;
         cpu_dado_lido_q <= '0;
         cpu_erro_q      <= 1'b0;
         dma_dado_lido_q <= '0;
         dma_erro_q      <= 1'b0;
      end else begin
         estado_q        <= estado_d;
         vencedor_q      <= vencedor_d;
         we_q            <= we_d;
         in_range_q      <= in_range_d;
         endereco_q      <= endereco_d;
         dado_q          <= dado_d;
         contador_q      <= contador_d;
         cpu_dado_lido_q <= cpu_dado_lido_d;
         cpu_erro_q      <= cpu_erro_d;
         dma_dado_lido_q <= dma_dado_lido_d;
         dma_erro_q      <= dma_erro_d;
      end
   end

   always_comb begin
      estado_d        = estado_q;
      vencedor_d      = vencedor_q;
      we_d            = we_q;
      in_range_d      = in_range_q;
      endereco_d      = endereco_q;
      dado_d          = dado_q;
      contador_d      = contador_q;
      cpu_dado_lido_d = cpu_dado_lido_q;
      cpu_erro_d      = cpu_erro_q;
      dma_dado_lido_d = dma_dado_lido_q;
      dma_erro_d      = dma_erro_q;
      leitura         = (!we_q && in_range_q) ? bus.mem_dado_lido : '0;

      case (estado_q)
         OCIOSO: begin
            if (concede) begin
               estado_d   = ACESSO;
               vencedor_d = vencedor;
               if (vencedor == CPU) begin
                  we_d       = bus.cpu_we;
                  endereco_d = bus.cpu_endereco;
                  dado_d     = bus.cpu_dado_escrito;
               end else begin
                  we_d       = bus.dma_we;
                  endereco_d = bus.dma_endereco;
                  dado_d     = bus.dma_dado_escrito;
               end
               in_range_d = endereco_valido(endereco_d, MEM_SIZE);
               // Only a CPU win over a waiting DMA counts towards starvation.
               if (vencedor == CPU && bus.dma_req) begin
                  if (contador_q != LIMITE) contador_d = contador_q + 1'b1;
               end else begin
                  contador_d = '0;
               end
            end
         end
         ACESSO: begin
            estado_d = RESPOSTA;
            if (vencedor_q == CPU) begin
               cpu_dado_lido_d = leitura;
               cpu_erro_d      = !in_range_q;
            end else begin
               dma_dado_lido_d = leitura;
               dma_erro_d      = !in_range_q;
            end
         end
         RESPOSTA: estado_d = OCIOSO;
         default:  estado_d = OCIOSO;
      endcase
   end

   // The address/data registers change only on a grant, so they double as the
   // memory bus outputs and naturally hold their values outside ACESSO.
   assign bus.mem_endereco     = endereco_q;
   assign bus.mem_dado_escrito = dado_q;
   assign bus.mem_memWrite     = (estado_q == ACESSO) && we_q && in_range_q;

   assign bus.cpu_ack       = (estado_q == RESPOSTA) && (vencedor_q == CPU);
   assign bus.dma_ack       = (estado_q == RESPOSTA) && (vencedor_q == DMA);
   assign bus.cpu_dado_lido = cpu_dado_lido_q;
   assign bus.cpu_erro      = cpu_erro_q;
   assign bus.dma_dado_lido = dma_dado_lido_q;
   assign bus.dma_erro      = dma_erro_q;

endmodule
